ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required to change the filtered clock level (range 2-16).
REQ-002 Parameter TIMEOUT, 50000, CLOCK_50 cycles without a filtered ps2_clk edge before an in-progress frame is aborted (1 ms at 50 MHz).
REQ-003 Parameter FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2-64.
REQ-004 Parameter DECODE_PREFIX, 1, 1 = merge E0/F0 prefixes into flags; 0 = pass every byte raw.
REQ-005 CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-006 Resetn  in  1  asynchronous, active-low reset.
REQ-007 ps2_clk  in  1  raw PS/2 clock, asynchronous to CLOCK_50.
REQ-008 ps2_dat  in  1  raw PS/2 data, asynchronous to CLOCK_50.
REQ-009 rd_en  in  1  pop request for the FIFO head.
REQ-010 clr_err  in  1  synchronous clear of overflow.
REQ-011 rd_data  out  10  FIFO head {ext, brk, code[7:0]}, show-ahead.
REQ-012 rd_valid  out  1  FIFO not empty.
REQ-013 fifo_count  out  clog2(FIFO_DEPTH)+1  current entries.
REQ-014 frame_err  out  1  one-cycle pulse per discarded frame.
REQ-015 overflow  out  1  sticky, set when a byte is dropped on a full FIFO.

Function
REQ-016 ps2_clk and ps2_dat SHALL each pass a 2-flop synchroniser; the filtered clock SHALL change level only after FILTER_LEN consecutive equal synchronised samples.
REQ-017 A bit SHALL be sampled from synchronised ps2_dat in the cycle the filtered clock goes 1->0.
REQ-018 FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on a sampled 0; a sampled 1 in IDLE SHALL be ignored.
REQ-019 DATA SHALL collect 8 bits LSB first, then go to PARITY; PARITY SHALL record the bit and go to STOP; STOP SHALL always return to IDLE.
REQ-020 A frame is good when data plus parity hold an odd number of ones and the stop bit is 1; otherwise the byte SHALL be discarded and frame_err pulsed the cycle after the stop sample.
REQ-021 A timeout counter SHALL clear on every filtered edge; if state is not IDLE when it reaches TIMEOUT-1, FSM SHALL return to IDLE and frame_err SHALL pulse once.
REQ-022 DECODE_PREFIX=1: good byte E0 sets ext, F0 sets brk, neither pushed; any other good byte pushes {ext,brk,byte} and clears both flags.
REQ-023 DECODE_PREFIX=0: every good byte SHALL push {0,0,byte}; flags stay 0.
REQ-024 Frame error or timeout SHALL clear ext and brk.
REQ-025 Push latency: entry written on the cycle after the stop-bit sample; rd_valid and rd_data valid the following cycle.
REQ-026 rd_en with rd_valid=1 SHALL pop; rd_en with rd_valid=0 SHALL be ignored.
REQ-027 Push on full FIFO without simultaneous pop SHALL drop the byte and set overflow; push and pop in the same cycle on full SHALL both succeed, count unchanged, no overflow.
REQ-028 Push and pop on empty FIFO: push succeeds, pop ignored, count becomes 1.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL reach exactly FIFO_DEPTH when full.
REQ-030 clr_err SHALL clear overflow next cycle; a simultaneous overflow event SHALL take priority (overflow stays 1).

Reset
REQ-031 Resetn=0 SHALL immediately force FSM IDLE, bit counter 0, timeout counter 0, filtered clock 1, synchronisers 1, ext=brk=0, FIFO empty.
REQ-032 During reset rd_data=0, rd_valid=0, fifo_count=0, frame_err=0, overflow=0; reset mid-frame SHALL discard the partial frame without frame_err.

Verification
REQ-033 Frame 0x1C, parity 0, stop 1 -> one entry rd_data=0x01C, fifo_count=1, frame_err=0.
REQ-034 Frames E0, F0, 75 (DECODE_PREFIX=1) -> single entry rd_data=0x375; with DECODE_PREFIX=0 -> three entries 0x0E0, 0x0F0, 0x075.
REQ-035 Frame 0x1C with parity 1 -> frame_err one-cycle pulse, fifo_count stays 0; next good 0x1C accepted.
REQ-036 Nine good frames 0x01..0x09, no reads, depth 8 -> fifo_count=8, overflow=1, reads return 0x001..0x008 in order; clr_err -> overflow=0.
REQ-037 Start bit plus 5 data bits then idle 50000 cycles -> frame_err pulse, FSM IDLE; following frame 0x2A received as 0x02A.
REQ-038 Resetn pulsed low after 4 data bits -> no entry, no frame_err; subsequent frame 0x1C received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ps2_rx_fifo : PS/2 receiver with clock filtering, frame checking, optional
//               E0/F0 prefix merging and a show-ahead scan-code FIFO.
// Revision    : 1.0
// ============================================================================
module ps2_rx_fifo #(
   parameter int FILTER_LEN    = 4,
   parameter int TIMEOUT       = 50000,
   parameter int FIFO_DEPTH    = 8,
   parameter int DECODE_PREFIX = 1
) (
   input  logic                          CLOCK_50,
   input  logic                          Resetn,
   input  logic                          ps2_clk,
   input  logic                          ps2_dat,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [9:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic [FW-1:0] r_flt_cnt;
   logic          r_flt_clk;
   logic          w_flt_done, w_fall, w_good;

   state_t        r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_to_cnt;
   logic          r_ext, r_brk;
   logic          r_push;
   logic [9:0]    r_push_data;
   logic          r_frame_err;

   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          w_empty, w_full, w_pop, w_wr, w_drop;

   // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
   assign w_flt_done = (r_clk_s2 != r_flt_clk) && (r_flt_cnt == FW'(FILTER_LEN - 1));
   assign w_fall     = w_flt_done && r_flt_clk;
   assign w_good     = (^{r_shift, r_par}) && r_dat_s2;

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_dat_s1  <= 1'b1;
         r_dat_s2  <= 1'b1;
         r_flt_cnt <= '0;
         r_flt_clk <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_dat;
         r_dat_s2 <= r_dat_s1;
         if (r_clk_s2 == r_flt_clk) begin
            r_flt_cnt <= '0;
         end else if (w_flt_done) begin
            r_flt_cnt <= '0;
            r_flt_clk <= r_clk_s2;
         end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_to_cnt    <= '0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_flt_done || r_state == S_IDLE)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + 1'b1;

         // A stalled frame is abandoned; a real edge in the same cycle wins
         if (r_state != S_IDLE && !w_flt_done && r_to_cnt == TW'(TIMEOUT - 1)) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
         end else if (w_fall) begin
            case (r_state)
               S_IDLE: begin
                  if (!r_dat_s2) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_PARITY;
               end
               S_PARITY: begin
                  r_par   <= r_dat_s2;
                  r_state <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  if (w_good) begin
                     if (DECODE_PREFIX != 0 && r_shift == 8'hE0) begin
                        r_ext <= 1'b1;
                     end else if (DECODE_PREFIX != 0 && r_shift == 8'hF0) begin
                        r_brk <= 1'b1;
                     end else begin
                        r_push      <= 1'b1;
                        r_push_data <= {r_ext, r_brk, r_shift};
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_ext       <= 1'b0;
                     r_brk       <= 1'b0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = rd_en && !w_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_wr    = r_push && (!w_full || w_pop);
   assign w_drop  = r_push && w_full && !w_pop;

   always_ff @(posedge CLOCK_50) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= r_push_data;
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clr_err)
            r_overflow <= 1'b0;
      end
   end

   assign rd_data    = w_empty ? 10'd0 : r_mem[r_rd_ptr];
   assign rd_valid   = !w_empty;
   assign fifo_count = r_count;
   assign frame_err  = r_frame_err;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ps2_rx_fifo : directed frame vectors plus hand-written corner sequences.
// Revision       : 1.0
// ============================================================================
module tb_ps2_rx_fifo;

   localparam int HALF = 10;

   logic       CLOCK_50 = 1'b0;
   logic       Resetn   = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_dat  = 1'b1;
   logic       rd_en    = 1'b0;
   logic       rd_en_raw = 1'b0;
   logic       clr_err  = 1'b0;
   logic [9:0] rd_data, rd_data_raw;
   logic       rd_valid, rd_valid_raw;
   logic [3:0] fifo_count, fifo_count_raw;
   logic       frame_err, frame_err_raw;
   logic       overflow, overflow_raw;

   int n_chk  = 0;
   int n_pass = 0;
   int err_cnt = 0;
   int e0;
   int waited;

   typedef struct {
      logic [7:0] data;
      bit         par_bad;
      bit         stop;
      bit         exp_push;
      bit         exp_err;
      logic [9:0] exp_rd;
   } vec_t;
   vec_t vecs[12];

   ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT(50000), .FIFO_DEPTH(8), .DECODE_PREFIX(1)) u_main (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow));

   ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT(50000), .FIFO_DEPTH(8), .DECODE_PREFIX(0)) u_raw (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .rd_en(rd_en_raw), .clr_err(clr_err), .rd_data(rd_data_raw), .rd_valid(rd_valid_raw),
      .fifo_count(fifo_count_raw), .frame_err(frame_err_raw), .overflow(overflow_raw));

   always #10 CLOCK_50 = ~CLOCK_50;

   // Counts high cycles, so a stretched pulse shows up as an extra error
   always @(negedge CLOCK_50) if (frame_err) err_cnt++;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic send_bit(input logic b);
      ps2_dat = b;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(~(^d) ^ par_bad);
      send_bit(stop);
      ps2_dat = 1'b1;
      tick(2 * HALF);
   endtask

   task automatic pop_main(input string name, input logic [9:0] exp);
      check(name, {22'd0, rd_data}, {22'd0, exp});
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic pop_raw(input string name, input logic [9:0] exp);
      check(name, {22'd0, rd_data_raw}, {22'd0, exp});
      rd_en_raw = 1'b1;
      tick(1);
      rd_en_raw = 1'b0;
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      tick(3);
      Resetn = 1'b1;
      tick(3);
   endtask

   initial begin
      //            data   pbad stop push err  rd
      vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 10'h01C};
      vecs[1]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 10'h000};
      vecs[2]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 10'h0FF};
      vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000};
      vecs[4]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000};
      vecs[5]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 10'h05A};
      vecs[6]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
      vecs[7]  = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 10'h000};
      vecs[8]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 10'h075};
      vecs[9]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
      vecs[10] = '{8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 10'h112};
      vecs[11] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 10'h000};

      tick(2);
      check("reset_rd_data",   {22'd0, rd_data}, 32'd0);
      check("reset_rd_valid",  {31'd0, rd_valid}, 32'd0);
      check("reset_count",     {28'd0, fifo_count}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overflow",  {31'd0, overflow}, 32'd0);
      Resetn = 1'b1;
      tick(3);

      // Single good frame
      e0 = err_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      check("single_count", {28'd0, fifo_count}, 32'd1);
      check("single_valid", {31'd0, rd_valid}, 32'd1);
      check("single_err",   err_cnt - e0, 32'd0);
      pop_main("single_data", 10'h01C);
      check("single_empty", {28'd0, fifo_count}, 32'd0);

      // Vector table
      for (int v = 0; v < 12; v++) begin
         e0 = err_cnt;
         send_frame(vecs[v].data, vecs[v].par_bad, vecs[v].stop);
         check($sformatf("vec%0d_err", v), err_cnt - e0, {31'd0, vecs[v].exp_err});
         check($sformatf("vec%0d_count", v), {28'd0, fifo_count}, {31'd0, vecs[v].exp_push});
         if (vecs[v].exp_push) pop_main($sformatf("vec%0d_data", v), vecs[v].exp_rd);
      end

      // Prefix merging versus raw mode
      do_reset();
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      check("prefix_count", {28'd0, fifo_count}, 32'd1);
      check("raw_count",    {28'd0, fifo_count_raw}, 32'd3);
      pop_main("prefix_data", 10'h375);
      pop_raw("raw_data0", 10'h0E0);
      pop_raw("raw_data1", 10'h0F0);
      pop_raw("raw_data2", 10'h075);
      check("raw_empty", {31'd0, rd_valid_raw}, 32'd0);

      // Overflow on a depth-8 FIFO
      do_reset();
      for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1);
      check("ovf_count", {28'd0, fifo_count}, 32'd8);
      check("ovf_flag",  {31'd0, overflow}, 32'd1);
      for (int k = 1; k <= 8; k++) pop_main($sformatf("ovf_data%0d", k), 10'(k));
      check("ovf_drained", {28'd0, fifo_count}, 32'd0);
      check("ovf_sticky",  {31'd0, overflow}, 32'd1);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // Timeout of a truncated frame
      do_reset();
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      e0 = err_cnt;
      waited = 0;
      while (err_cnt == e0 && waited < 50200) begin
         tick(1);
         waited++;
      end
      tick(2);
      check("timeout_err", err_cnt - e0, 32'd1);
      check("timeout_window", (waited >= 49980 && waited <= 50030) ? 32'd1 : 32'd0, 32'd1);
      check("timeout_count", {28'd0, fifo_count}, 32'd0);
      e0 = err_cnt;
      send_frame(8'h2A, 1'b0, 1'b1);
      check("after_to_err", err_cnt - e0, 32'd0);
      check("after_to_count", {28'd0, fifo_count}, 32'd1);
      pop_main("after_to_data", 10'h02A);

      // Reset in the middle of a frame
      do_reset();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      e0 = err_cnt;
      Resetn = 1'b0;
      tick(2);
      check("midrst_valid", {31'd0, rd_valid}, 32'd0);
      check("midrst_ferr",  {31'd0, frame_err}, 32'd0);
      Resetn = 1'b1;
      tick(4 * HALF);
      check("midrst_count", {28'd0, fifo_count}, 32'd0);
      check("midrst_noerr", err_cnt - e0, 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check("midrst_err2", err_cnt - e0, 32'd0);
      check("midrst_count2", {28'd0, fifo_count}, 32'd1);
      pop_main("midrst_data", 10'h01C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
